// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS controller: Moore FSM sequencing a shared-memory datapath.
// Latency: R/imm/SW 4 cycles, LW/LBU 5, BEQ/J 3; each mem_ready-low cycle adds one.
// Backpressure: mem_ready stalls FETCH/MEMRD/MEMWR; TIMEOUT_CYCLES low cycles trap.
// Optional LBU decode is enabled by defining MIPS_CTRL_LBU_EN.
module mips_multicycle_ctrl #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       iord,
  output logic       memwrite,
  output logic       irwrite,
  output logic       pcen,
  output logic [1:0] pcsrc,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [3:0] alucontrol,
  output logic       signext,
  output logic       shiftl16,
  output logic       regdst,
  output logic       memtoreg,
  output logic       regwrite,
  output logic       lb_en,
  output logic       fault,
  output logic [3:0] state
);

  localparam logic [3:0] S_FETCH  = 4'd0;
  localparam logic [3:0] S_DECODE = 4'd1;
  localparam logic [3:0] S_MEMADR = 4'd2;
  localparam logic [3:0] S_MEMRD  = 4'd3;
  localparam logic [3:0] S_MEMWB  = 4'd4;
  localparam logic [3:0] S_MEMWR  = 4'd5;
  localparam logic [3:0] S_EXEC   = 4'd6;
  localparam logic [3:0] S_ALUWB  = 4'd7;
  localparam logic [3:0] S_BRANCH = 4'd8;
  localparam logic [3:0] S_IMMEX  = 4'd9;
  localparam logic [3:0] S_IMMWB  = 4'd10;
  localparam logic [3:0] S_JUMP   = 4'd11;
  localparam logic [3:0] S_TRAP   = 4'd15;

  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b1010;
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_XOR = 4'b0100;
  localparam logic [3:0] ALU_SLT = 4'b1011;

  logic [3:0]       state_q, state_d;
  logic [CNT_W-1:0] wait_cnt;
  logic             mem_state, timeout;
  logic [3:0]       r_alu;
  logic             r_ok;

  assign mem_state = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);
  // Last allowed low cycle: if memory still isn't ready now, give up next cycle.
  assign timeout   = mem_state && !mem_ready && (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  // R-type funct decode, shared by EXEC and ALUWB so alucontrol stays stable.
  always_comb begin
    r_ok  = 1'b1;
    r_alu = ALU_AND;
    case (funct)
      6'b100000, 6'b100001: r_alu = ALU_ADD;
      6'b100010, 6'b100011: r_alu = ALU_SUB;
      6'b100100:            r_alu = ALU_AND;
      6'b100101:            r_alu = ALU_OR;
      6'b100110:            r_alu = ALU_XOR;
      6'b101010:            r_alu = ALU_SLT;
      default:              r_ok  = 1'b0;
    endcase
  end

  // Next-state logic; unused encodings fall into TRAP.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:  if (mem_ready) state_d = S_DECODE; else if (timeout) state_d = S_TRAP;
      S_DECODE: begin
        case (op)
          6'b000000:                       state_d = S_EXEC;
          6'b100011, 6'b101011:            state_d = S_MEMADR;
`ifdef MIPS_CTRL_LBU_EN
          6'b100100:                       state_d = S_MEMADR;
`endif
          6'b000100:                       state_d = S_BRANCH;
          6'b001000, 6'b001001, 6'b001101,
          6'b001110, 6'b001111:            state_d = S_IMMEX;
          6'b000010:                       state_d = S_JUMP;
          default:                         state_d = S_TRAP;
        endcase
      end
      S_MEMADR: state_d = (op == 6'b101011) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  if (mem_ready) state_d = S_MEMWB; else if (timeout) state_d = S_TRAP;
      S_MEMWR:  if (mem_ready) state_d = S_FETCH; else if (timeout) state_d = S_TRAP;
      S_EXEC:   state_d = r_ok ? S_ALUWB : S_TRAP;
      S_IMMEX:  state_d = S_IMMWB;
      S_MEMWB, S_ALUWB, S_IMMWB, S_BRANCH, S_JUMP: state_d = S_FETCH;
      S_TRAP:   state_d = S_TRAP;
      default:  state_d = S_TRAP;
    endcase
  end

  // State and wait counter; counter runs only while stalled in the same memory state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_FETCH;
      wait_cnt <= '0;
    end else begin
      state_q  <= state_d;
      if (mem_state && !mem_ready && (state_d == state_q))
        wait_cnt <= wait_cnt + 1'b1;
      else
        wait_cnt <= '0;
    end
  end

  // Moore outputs; strobes forced low while reset is asserted.
  always_comb begin
    iord = 1'b0; memwrite = 1'b0; irwrite = 1'b0; pcen = 1'b0;
    pcsrc = 2'b00; alusrca = 1'b0; alusrcb = 2'b00; alucontrol = ALU_AND;
    signext = 1'b0; shiftl16 = 1'b0; regdst = 1'b0; memtoreg = 1'b0;
    regwrite = 1'b0; lb_en = 1'b0;
    case (state_q)
      S_FETCH: begin
        alusrcb = 2'b01; alucontrol = ALU_ADD;
        irwrite = mem_ready; pcen = mem_ready;
      end
      S_DECODE: begin
        alusrcb = 2'b11; signext = 1'b1; alucontrol = ALU_ADD;
      end
      S_MEMADR: begin
        alusrca = 1'b1; alusrcb = 2'b10; signext = 1'b1; alucontrol = ALU_ADD;
      end
      S_MEMRD: iord = 1'b1;
      S_MEMWB: begin
        memtoreg = 1'b1; regwrite = 1'b1;
`ifdef MIPS_CTRL_LBU_EN
        lb_en = (op == 6'b100100);
`endif
      end
      S_MEMWR: begin
        iord = 1'b1; memwrite = 1'b1;
      end
      S_EXEC: begin
        alusrca = 1'b1; alucontrol = r_alu;
      end
      S_ALUWB: begin
        regdst = 1'b1; regwrite = r_ok; alucontrol = r_alu;
      end
      S_BRANCH: begin
        alusrca = 1'b1; alucontrol = ALU_SUB; pcsrc = 2'b01; pcen = zero;
      end
      S_IMMEX, S_IMMWB: begin
        if (state_q == S_IMMEX) begin
          alusrca = 1'b1; alusrcb = 2'b10;
        end else begin
          regwrite = 1'b1;
        end
        case (op)
          6'b001000, 6'b001001: begin signext = 1'b1; alucontrol = ALU_ADD; end
          6'b001101:            alucontrol = ALU_OR;
          6'b001110:            alucontrol = ALU_XOR;
          6'b001111:            begin shiftl16 = 1'b1; alucontrol = ALU_ADD; end
          default:              alucontrol = ALU_AND;
        endcase
      end
      S_JUMP: begin
        pcsrc = 2'b10; pcen = 1'b1;
      end
      default: ;
    endcase
    if (reset) begin
      memwrite = 1'b0; irwrite = 1'b0; pcen = 1'b0; regwrite = 1'b0;
    end
  end

  assign fault = (state_q == S_TRAP);
  assign state = state_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed bench for mips_multicycle_ctrl: walks each instruction class
// through its state sequence and checks the controls of every state.
// Inputs change just after the falling edge; outputs are read 1 time unit later.
module tb_mips_multicycle_ctrl;
  logic       clk = 1'b0;
  logic       reset, zero, mem_ready;
  logic [5:0] op, funct;
  logic       iord, memwrite, irwrite, pcen, alusrca, signext, shiftl16;
  logic       regdst, memtoreg, regwrite, lb_en, fault;
  logic [1:0] pcsrc, alusrcb;
  logic [3:0] alucontrol, state;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  mips_multicycle_ctrl #(.TIMEOUT_CYCLES(16), .CNT_W(5)) dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .iord(iord), .memwrite(memwrite), .irwrite(irwrite),
    .pcen(pcen), .pcsrc(pcsrc), .alusrca(alusrca), .alusrcb(alusrcb),
    .alucontrol(alucontrol), .signext(signext), .shiftl16(shiftl16),
    .regdst(regdst), .memtoreg(memtoreg), .regwrite(regwrite), .lb_en(lb_en),
    .fault(fault), .state(state)
  );

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock and settle at the next sampling point.
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // Hold reset for one edge, checking strobes are quiet meanwhile.
  task automatic do_reset(input logic [5:0] o, input logic [5:0] f);
    @(negedge clk);
    reset = 1'b1; op = o; funct = f; mem_ready = 1'b1; zero = 1'b0;
    #1;
    check("rst_strobes", {4'b0, memwrite, irwrite, pcen, regwrite}, 8'h00);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_state", {4'b0, state}, 8'd0);
    check("rst_fault", {7'b0, fault}, 8'd0);
  endtask

  int pc_pulses;
  int ok_cycles;

  initial begin
    reset = 1'b1; op = '0; funct = '0; zero = 1'b0; mem_ready = 1'b1;

    // ADD: 0,1,6,7,0 with a single pcen pulse in FETCH
    do_reset(6'b000000, 6'b100000);
    pc_pulses = 0;
    check("add_f_irw", {7'b0, irwrite}, 8'd1);
    check("add_f_srcb", {6'b0, alusrcb}, 8'd1);
    pc_pulses += int'(pcen); step();
    check("add_d_state", {4'b0, state}, 8'd1);
    check("add_d_srcb", {6'b0, alusrcb}, 8'd3);
    pc_pulses += int'(pcen); step();
    check("add_e_state", {4'b0, state}, 8'd6);
    check("add_e_alu", {4'b0, alucontrol}, 8'b0010);
    pc_pulses += int'(pcen); step();
    check("add_wb_state", {4'b0, state}, 8'd7);
    check("add_wb_ctl", {5'b0, regwrite, regdst, memtoreg}, 8'b110);
    check("add_wb_alu", {4'b0, alucontrol}, 8'b0010);
    pc_pulses += int'(pcen); step();
    check("add_end_state", {4'b0, state}, 8'd0);
    check("add_pcen_pulses", 8'(pc_pulses), 8'd1);

    // FETCH stall: no IR/PC update while memory is busy
    mem_ready = 1'b0; #1;
    check("fetch_stall", {6'b0, irwrite, pcen}, 8'd0);
    step();
    check("fetch_stall_state", {4'b0, state}, 8'd0);
    mem_ready = 1'b1;

    // LW with three wait cycles in MEMRD: 8 cycles total
    do_reset(6'b100011, 6'b0);
    step(); step();
    check("lw_adr_state", {4'b0, state}, 8'd2);
    check("lw_adr_ctl", {4'b0, alusrca, alusrcb, signext}, 8'b1101);
    step();
    mem_ready = 1'b0; #1;
    for (int i = 0; i < 3; i++) begin
      check("lw_rd_wait", {3'b0, iord, state}, 8'h13);
      step();
    end
    mem_ready = 1'b1; #1;
    check("lw_rd_done", {4'b0, state}, 8'd3);
    step();
    check("lw_wb_state", {4'b0, state}, 8'd4);
    check("lw_wb_ctl", {5'b0, memtoreg, regwrite, lb_en}, 8'b110);
    check("lw_fault", {7'b0, fault}, 8'd0);
    step();
    check("lw_end_state", {4'b0, state}, 8'd0);

    // BEQ taken and not taken
    for (int z = 1; z >= 0; z--) begin
      do_reset(6'b000100, 6'b0);
      zero = 1'(z);
      step(); step();
      check("beq_state", {4'b0, state}, 8'd8);
      check("beq_pcen", {7'b0, pcen}, 8'(z));
      check("beq_pcsrc_alu", {2'b0, pcsrc, alucontrol}, 8'b01_1010);
      step();
      check("beq_next", {4'b0, state}, 8'd0);
    end
    zero = 1'b0;

    // J
    do_reset(6'b000010, 6'b0);
    step(); step();
    check("j_ctl", {1'b0, pcen, pcsrc, state}, {1'b0, 1'b1, 2'b10, 4'd11});

    // SW hung for 16 cycles: memwrite throughout, then TRAP
    do_reset(6'b101011, 6'b0);
    step(); step(); step();
    mem_ready = 1'b0; #1;
    ok_cycles = 0;
    for (int i = 0; i < 16; i++) begin
      if (memwrite === 1'b1 && state === 4'd5) ok_cycles++;
      step();
    end
    check("sw_memwrite_held", 8'(ok_cycles), 8'd16);
    check("sw_trap_state", {4'b0, state}, 8'd15);
    check("sw_trap_ctl", {6'b0, fault, memwrite}, 8'b10);
    mem_ready = 1'b1;
    step();
    check("trap_sticky", {3'b0, fault, state}, 8'h1f);
    do_reset(6'b101011, 6'b0);

    // SW timeout boundary: ready on the 16th low cycle completes normally
    step(); step(); step();
    mem_ready = 1'b0;
    for (int i = 0; i < 15; i++) step();
    mem_ready = 1'b1; #1;
    check("sw_last_cycle", {3'b0, memwrite, state}, 8'h15);
    step();
    check("sw_late_ok", {3'b0, fault, state}, 8'h00);

    // Reset in MEMWR: strobes low during reset, FETCH afterwards
    step(); step(); step();
    mem_ready = 1'b0; #1;
    check("mid_memwr", {7'b0, memwrite}, 8'd1);
    do_reset(6'b101011, 6'b0);

    // Illegal opcode
    do_reset(6'b111111, 6'b0);
    step(); step();
    check("illegal_op", {3'b0, fault, state}, 8'h1f);

    // Illegal funct: TRAP from EXEC, no regwrite
    do_reset(6'b000000, 6'b000000);
    step(); step();
    check("badfunct_exec", {3'b0, regwrite, state}, 8'h06);
    step();
    check("badfunct_trap", {3'b0, regwrite, state}, 8'h0f);

    // LBU, build dependent
    do_reset(6'b100100, 6'b0);
    step(); step();
`ifdef MIPS_CTRL_LBU_EN
    check("lbu_adr", {4'b0, state}, 8'd2);
    step(); step();
    check("lbu_wb", {3'b0, lb_en, state}, 8'h14);
    step();
    check("lbu_end", {4'b0, state}, 8'd0);
`else
    check("lbu_trap", {3'b0, lb_en, state}, 8'h0f);
`endif

    // XORI: zero-extend, xor in IMMEX and IMMWB
    do_reset(6'b001110, 6'b0);
    step(); step();
    check("xori_ex", {signext, alusrca, alusrcb, state}, {1'b0, 1'b1, 2'b10, 4'd9});
    check("xori_alu", {4'b0, alucontrol}, 8'b0100);
    step();
    check("xori_wb", {1'b0, regwrite, regdst, signext, state}, {1'b0, 1'b1, 1'b0, 1'b0, 4'd10});
    check("xori_wb_alu", {4'b0, alucontrol}, 8'b0100);

    // LUI: shift by 16, add
    do_reset(6'b001111, 6'b0);
    step(); step();
    check("lui_ex", {3'b0, shiftl16, alucontrol}, 8'h12);

    // ADDI: sign-extend
    do_reset(6'b001000, 6'b0);
    step(); step();
    check("addi_ex", {3'b0, signext, alucontrol}, 8'h12);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/mips_multicycle_ctrl.md
Name: mips_multicycle_ctrl

Overview:
- Moore FSM controller that sequences a multicycle MIPS datapath: one shared memory for instructions and data, one ALU, and a registered IR, A, B, ALUOut and data register.
- Replaces the single-cycle main decoder / ALU decoder pair.
- Adds a memory wait-state handshake (mem_ready), a wait timeout, and a sticky fault trap for illegal opcodes or hung memory.
- Drives the same 4-bit ALU control encoding as the existing ALU.

Parameters:
- TIMEOUT_CYCLES, 16: consecutive mem_ready-low cycles in any memory state before entering TRAP (must be ≥1).
- CNT_W, 5: width of the wait counter (must hold TIMEOUT_CYCLES).

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- op  in  6  IR[31:26], held stable by datapath IR
- funct  in  6  IR[5:0]
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes access this cycle
- iord  out  1  memory address: 0=PC, 1=ALUOut
- memwrite  out  1  memory write strobe
- irwrite  out  1  load IR
- pcen  out  1  PC register enable
- pcsrc  out  2  00 ALU result, 01 ALUOut, 10 jump target
- alusrca  out  1  0=PC, 1=A
- alusrcb  out  2  00 B, 01 constant 4, 10 extended imm, 11 extended imm<<2
- alucontrol  out  4  0010 add, 1010 sub, 0000 and, 0001 or, 0100 xor, 1011 slt
- signext  out  1  1=sign-extend imm, 0=zero-extend
- shiftl16  out  1  imm<<16 (LUI)
- regdst  out  1  0=rt, 1=rd
- memtoreg  out  1  writeback from data register
- regwrite  out  1  register file write
- lb_en  out  1  byte-select/zero-extend on load writeback
- fault  out  1  sticky; controller halted in TRAP
- state  out  4  current state encoding, for debug

Behaviour:
- Reset: state=FETCH, wait counter=0, fault=0. All strobes (memwrite, irwrite, pcen, regwrite) are 0 during the reset cycle.
- Outputs are a function of state only, except:
  - pcen/irwrite in FETCH are gated by mem_ready;
  - pcen in BRANCH is gated by zero.
- State encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, IMMEX=9, IMMWB=10, JUMP=11, TRAP=15.
- FETCH:
  - iord=0, alusrca=0, alusrcb=01, add, pcsrc=00.
  - If mem_ready: irwrite=1, pcen=1, go to DECODE; else stay.
- DECODE: alusrca=0, alusrcb=11, signext=1, add (branch target into ALUOut). Next state by op:
  - 000000 → EXEC
  - 100011 / 101011 / 100100 → MEMADR
  - 000100 → BRANCH
  - 001000 / 001001 / 001101 / 001110 / 001111 → IMMEX
  - 000010 → JUMP
  - otherwise → TRAP
- MEMADR: alusrca=1, alusrcb=10, signext=1, add. Go to MEMWR if op=101011, else MEMRD.
- MEMRD: iord=1. Wait for mem_ready, then MEMWB.
- MEMWB: regdst=0, memtoreg=1, regwrite=1, lb_en=1 iff op=100100. Then FETCH.
- MEMWR:
  - iord=1, memwrite=1, held continuously until mem_ready.
  - When mem_ready: go to FETCH; memwrite drops the following cycle.
- EXEC:
  - alusrca=1, alusrcb=00.
  - alucontrol from funct: 100000/100001 add, 100010/100011 sub, 100100 and, 100101 or, 100110 xor, 101010 slt.
  - Other funct → TRAP with no writeback. Otherwise → ALUWB.
- ALUWB: regdst=1, regwrite=1, then FETCH.
- BRANCH: alusrca=1, alusrcb=00, sub, pcsrc=01, pcen=zero. Then FETCH.
- IMMEX: alusrca=1, alusrcb=10.
  - ADDI/ADDIU: signext=1, add.
  - ORI: or.
  - XORI: xor.
  - LUI: shiftl16=1, add.
  - Then IMMWB.
- IMMWB: regdst=0, regwrite=1; signext/shiftl16/alucontrol held from IMMEX. Then FETCH.
- JUMP: pcsrc=10, pcen=1. Then FETCH.
- Latency with mem_ready always 1:
  - R-type 4 cycles, LW/LBU 5, SW 4, BEQ 3, J 3, immediate ops 4.
  - Each mem_ready-low cycle adds one cycle.
- Wait counter:
  - Increments each cycle in FETCH/MEMRD/MEMWR with mem_ready=0.
  - Clears on mem_ready=1 or on leaving the state.
  - Reaching TIMEOUT_CYCLES → TRAP next cycle. mem_ready=1 on that same cycle takes priority: the access completes normally.
- TRAP: all strobes 0, fault=1, no exit except reset.
- Reset mid-operation (any state, including MEMWR with memwrite high): next cycle is FETCH with all strobes low; no partial writeback.
- Unused mux selects drive 0, never X.

Optional Feature:
- Macro: MIPS_CTRL_LBU_EN.
- Defined: opcode 100100 (LBU) is decoded as above, with lb_en=1 in MEMWB.
- Undefined: 100100 is illegal (DECODE → TRAP) and lb_en is constant 0.

Test Plan:
- Reset, mem_ready=1, IR=add $3,$1,$2 (op 000000, funct 100000) → states 0,1,6,7,0. ALUWB has regwrite=1, regdst=1, alucontrol=0010. pcen pulses once, in FETCH.
- LW with mem_ready low for 3 cycles in MEMRD → 8 cycles total. MEMWB has memtoreg=1, regwrite=1, lb_en=0. fault=0.
- BEQ: zero=1 → pcen=1, pcsrc=01 in BRANCH. Repeat with zero=0 → pcen=0; next state FETCH in both cases.
- SW with mem_ready=0 held for TIMEOUT_CYCLES=16 cycles → memwrite high throughout, then TRAP with fault=1 and memwrite=0. Further mem_ready is ignored. reset → FETCH, fault=0.
- Illegal op 111111 → TRAP after DECODE. R-type funct 000000 → TRAP from EXEC with regwrite never asserted.
- With MIPS_CTRL_LBU_EN defined: op 100100 → 5-cycle sequence with lb_en=1 in MEMWB. Undefined: TRAP after DECODE. XORI → IMMEX alucontrol=0100, signext=0.
